// File: rtl/exe_stage_pkg.sv
// Shared execute-stage definitions: bus layouts, store/load/divide encodings, the ALU.
// Combinational helpers only; no timing or backpressure of its own.
package exe_stage_pkg;

   localparam int DS_TO_ES_BUS_WD = 157;
   localparam int ES_TO_MS_BUS_WD = 77;

   localparam logic [1:0] DIV_W  = 2'b00;
   localparam logic [1:0] MOD_W  = 2'b01;
   localparam logic [1:0] DIV_WU = 2'b10;
   localparam logic [1:0] MOD_WU = 2'b11;

   localparam logic [1:0] ST_W = 2'b00;
   localparam logic [1:0] ST_B = 2'b01;
   localparam logic [1:0] ST_H = 2'b10;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_H  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [11:0] alu_op;
      logic [31:0] alu_src1;
      logic [31:0] alu_src2;
      logic [31:0] rkd_value;
      logic        div_en;
      logic [1:0]  div_op;
      logic        res_from_mem;
      logic [2:0]  ld_type;
      logic        mem_we;
      logic [1:0]  st_type;
      logic        gr_we;
      logic [4:0]  dest;
      logic        inst_no_dest;
      logic [31:0] pc;
   } ds_to_es_t;

   typedef struct packed {
      logic        res_from_mem;
      logic [2:0]  ld_type;
      logic        gr_we;
      logic [1:0]  st_type;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
      logic        inst_no_dest;
   } es_to_ms_t;

   // One-hot op: add sub slt sltu and nor or xor sll srl sra lui (bit 0 upward).
   function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      if (op[0])  r |= a + b;
      if (op[1])  r |= a - b;
      if (op[2])  r |= {31'b0, ($signed(a) < $signed(b))};
      if (op[3])  r |= {31'b0, (a < b)};
      if (op[4])  r |= a & b;
      if (op[5])  r |= ~(a | b);
      if (op[6])  r |= a | b;
      if (op[7])  r |= a ^ b;
      if (op[8])  r |= a << b[4:0];
      if (op[9])  r |= a >> b[4:0];
      if (op[10]) r |= $unsigned($signed(a) >>> b[4:0]);
      if (op[11]) r |= b;
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring 32-bit divider: start in IDLE, 32 BUSY cycles, result held in DONE.
// Done is level; DONE is left only when ack is seen, so the result holds under downstream stall.
module div_iter
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        ack,
   output logic        done,
   output logic [31:0] result
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] quo_q, rem_q, dsr_q, dvd_q;
   logic        q_neg_q, r_neg_q, dbz_q, rem_sel_q;

   logic        a_neg, b_neg;
   logic [31:0] dvd_abs, dsr_abs;
   logic [32:0] rem_shift;
   logic [33:0] trial;
   logic [31:0] q_out, r_out;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= DIV_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (start)          state_d = DIV_BUSY;
         DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
         DIV_DONE: if (ack)            state_d = DIV_IDLE;
         default:                      state_d = DIV_IDLE;
      endcase
   end

   // Operate on magnitudes; signs are re-applied on the way out.
   always_comb begin
      a_neg     = ~div_op[1] & dividend[31];
      b_neg     = ~div_op[1] & divisor[31];
      dvd_abs   = a_neg ? (~dividend + 32'd1) : dividend;
      dsr_abs   = b_neg ? (~divisor + 32'd1) : divisor;
      rem_shift = {rem_q, quo_q[31]};
      trial     = {1'b0, rem_shift} - {2'b00, dsr_q};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dsr_q     <= '0;
         dvd_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dbz_q     <= 1'b0;
         rem_sel_q <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  cnt_q     <= '0;
                  quo_q     <= dvd_abs;
                  rem_q     <= '0;
                  dsr_q     <= dsr_abs;
                  dvd_q     <= dividend;
                  q_neg_q   <= a_neg ^ b_neg;
                  r_neg_q   <= a_neg;
                  dbz_q     <= (divisor == 32'd0);
                  rem_sel_q <= div_op[0];
               end
            end
            DIV_BUSY: begin
               cnt_q <= cnt_q + 5'd1;
               if (!trial[33]) begin
                  rem_q <= trial[31:0];
                  quo_q <= {quo_q[30:0], 1'b1};
               end else begin
                  rem_q <= rem_shift[31:0];
                  quo_q <= {quo_q[30:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   // Divide by zero bypasses sign fixup: all-ones quotient, untouched dividend as remainder.
   always_comb begin
      q_out = q_neg_q ? (~quo_q + 32'd1) : quo_q;
      r_out = r_neg_q ? (~rem_q + 32'd1) : rem_q;
      if (dbz_q) begin
         q_out = '1;
         r_out = dvd_q;
      end
      result = rem_sel_q ? r_out : q_out;
   end

   assign done = (state_q == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU ops leave after 1 cycle, divides after 34; issues data SRAM requests.
// Holds its instruction while ms_allowin is low; es_allowin drops until the instruction can leave.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic [4:0]                 es_to_ds_dest,
   output logic [31:0]                es_to_ds_result,
   output logic                       es_to_ds_load,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_we,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata,
   output logic [31:0]                debug_es_pc
);

   logic        es_valid;
   logic        es_ready_go;
   ds_to_es_t   es_r;
   logic [31:0] alu_result;
   logic [31:0] div_result;
   logic        div_done;
   logic [31:0] final_result;
   logic [3:0]  st_we;
   logic [31:0] st_wdata;
   es_to_ms_t   ms_bus;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)         es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
   end

   // Payload register is deliberately unreset; every consumer is qualified by es_valid.
   always_ff @(posedge clk) begin
      if (ds_to_es_valid && es_allowin) es_r <= ds_to_es_bus;
   end

   assign alu_result = alu_calc(es_r.alu_op, es_r.alu_src1, es_r.alu_src2);

   div_iter u_div (
      .clk      (clk),
      .resetn   (resetn),
      .start    (es_valid & es_r.div_en),
      .div_op   (es_r.div_op),
      .dividend (es_r.alu_src1),
      .divisor  (es_r.alu_src2),
      .ack      (ms_allowin),
      .done     (div_done),
      .result   (div_result)
   );

   assign es_ready_go    = ~es_r.div_en | div_done;
   assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
   assign es_to_ms_valid = es_valid & es_ready_go;
   assign final_result   = es_r.div_en ? div_result : alu_result;

   always_comb begin
      st_we    = 4'b0000;
      st_wdata = es_r.rkd_value;
      case (es_r.st_type)
         ST_W: if (alu_result[1:0] == 2'b00) st_we = 4'b1111;
         ST_B: begin
            st_we    = 4'b0001 << alu_result[1:0];
            st_wdata = {4{es_r.rkd_value[7:0]}};
         end
         ST_H: begin
            case (alu_result[1:0])
               2'b00:   st_we = 4'b0011;
               2'b10:   st_we = 4'b1100;
               default: st_we = 4'b0000;
            endcase
            st_wdata = {2{es_r.rkd_value[15:0]}};
         end
         default: st_we = 4'b0000;
      endcase
   end

   // A request fires only in the cycle the instruction actually moves to MEM.
   assign data_sram_en    = es_valid & es_ready_go & ms_allowin & (es_r.res_from_mem | es_r.mem_we);
   assign data_sram_we    = (es_valid & es_r.mem_we) ? st_we : 4'b0000;
   assign data_sram_addr  = es_valid ? alu_result : 32'd0;
   assign data_sram_wdata = es_valid ? st_wdata : 32'd0;

   always_comb begin
      ms_bus.res_from_mem = es_r.res_from_mem;
      ms_bus.ld_type      = es_r.ld_type;
      ms_bus.gr_we        = es_r.gr_we;
      ms_bus.st_type      = es_r.st_type;
      ms_bus.dest         = es_r.dest;
      ms_bus.alu_result   = final_result;
      ms_bus.pc           = es_r.pc;
      ms_bus.inst_no_dest = es_r.inst_no_dest;
   end

   assign es_to_ms_bus    = es_valid ? ms_bus : '0;
   assign es_to_ds_dest   = (es_valid & ~es_r.inst_no_dest) ? es_r.dest : 5'd0;
   assign es_to_ds_load   = es_valid & es_r.res_from_mem;
   assign es_to_ds_result = es_valid ? final_result : 32'd0;
   assign debug_es_pc     = es_valid ? es_r.pc : 32'd0;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against a behavioural model of the stage's rules.
module tb_exe_stage;
   import exe_stage_pkg::*;

   logic                       clk = 1'b0;
   logic                       resetn;
   logic                       ms_allowin;
   logic                       es_allowin;
   logic                       ds_to_es_valid;
   logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic [4:0]                 es_to_ds_dest;
   logic [31:0]                es_to_ds_result;
   logic                       es_to_ds_load;
   logic                       data_sram_en;
   logic [3:0]                 data_sram_we;
   logic [31:0]                data_sram_addr;
   logic [31:0]                data_sram_wdata;
   logic [31:0]                debug_es_pc;

   int n_chk  = 0;
   int n_pass = 0;

   exe_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .es_to_ds_dest   (es_to_ds_dest),
      .es_to_ds_result (es_to_ds_result),
      .es_to_ds_load   (es_to_ds_load),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .debug_es_pc     (debug_es_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF;
         r = a;
      end else if (!op[1]) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
      int idx = 0;
      for (int i = 0; i < 12; i++) if (op[i]) idx = i;
      case (idx)
         0:  return a + b;
         1:  return a - b;
         2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return a << (b % 32);
         9:  return a >> (b % 32);
         10: return $unsigned($signed(a) >>> (b % 32));
         default: return b;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(input ds_to_es_t d);
      logic [63:0] qr;
      if (d.div_en) begin
         qr = ref_div(d.div_op, d.alu_src1, d.alu_src2);
         return d.div_op[0] ? qr[31:0] : qr[63:32];
      end
      return ref_alu(d.alu_op, d.alu_src1, d.alu_src2);
   endfunction

   // Returns {we, wdata} for a store at addr.
   function automatic logic [35:0] ref_store(input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data);
      int lane = int'(addr % 4);
      logic [3:0]  we;
      logic [31:0] wd;
      case (st)
         2'd0: begin we = (lane == 0) ? 4'd15 : 4'd0; wd = data; end
         2'd1: begin we = 4'(1 << lane); wd = data[7:0] * 32'h01010101; end
         2'd2: begin
            we = (lane == 0) ? 4'd3 : (lane == 2) ? 4'd12 : 4'd0;
            wd = data[15:0] * 32'h00010001;
         end
         default: begin we = 4'd0; wd = data; end
      endcase
      return {we, wd};
   endfunction

   function automatic ds_to_es_t mk_base();
      ds_to_es_t d;
      d           = '0;
      d.pc        = $urandom & 32'hFFFFFFFC;
      d.dest      = 5'($urandom_range(1, 31));
      d.gr_we     = 1'b1;
      d.rkd_value = $urandom;
      d.alu_op    = 12'd1;
      return d;
   endfunction

   function automatic ds_to_es_t mk_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
      ds_to_es_t d = mk_base();
      d.alu_op       = 12'(1 << idx);
      d.alu_src1     = a;
      d.alu_src2     = b;
      d.inst_no_dest = ($urandom_range(0, 3) == 0);
      return d;
   endfunction

   function automatic ds_to_es_t mk_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      ds_to_es_t d = mk_base();
      d.div_en   = 1'b1;
      d.div_op   = op;
      d.alu_src1 = a;
      d.alu_src2 = b;
      return d;
   endfunction

   function automatic ds_to_es_t mk_load(input logic [31:0] addr);
      ds_to_es_t d = mk_base();
      d.alu_src1     = addr;
      d.res_from_mem = 1'b1;
      d.ld_type      = 3'($urandom_range(0, 4));
      return d;
   endfunction

   function automatic ds_to_es_t mk_store(input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data);
      ds_to_es_t d = mk_base();
      d.alu_src1     = addr;
      d.mem_we       = 1'b1;
      d.st_type      = st;
      d.rkd_value    = data;
      d.gr_we        = 1'b0;
      d.inst_no_dest = 1'b1;
      return d;
   endfunction

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Enter one instruction, hold ms_allowin low for its first `stall` valid cycles, check every cycle.
   task automatic issue(input ds_to_es_t ins, input int stall, output int lat,
                        output logic [31:0] res, output logic [3:0] we, output logic [31:0] wd);
      logic [31:0]  exp_res = ref_result(ins);
      logic [35:0]  st      = ref_store(ins.st_type, exp_res, ins.rkd_value);
      logic [76:0]  exp_bus;
      logic [159:0] junk;
      logic         mem     = ins.res_from_mem | ins.mem_we;
      int           exp_lat = ins.div_en ? 33 : 0;
      int           vcnt    = 0;
      logic         done    = 1'b0;
      logic         rdy;
      exp_bus = {ins.res_from_mem, ins.ld_type, ins.gr_we, ins.st_type, ins.dest,
                 exp_res, ins.pc, ins.inst_no_dest};
      lat = -1; res = '0; we = '0; wd = '0;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = ins;
      #2;
      chk("allowin_empty", es_allowin, 1'b1);
      @(posedge clk); #1;
      ds_to_es_valid = 1'b0;
      junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ds_to_es_bus = junk[DS_TO_ES_BUS_WD-1:0];
      for (int c = 0; c < 120; c++) begin
         ms_allowin = (vcnt >= stall);
         #2;
         rdy = (c >= exp_lat);
         chk("ms_valid", es_to_ms_valid, rdy);
         chk("allowin", es_allowin, rdy && ms_allowin);
         chk("sram_en", data_sram_en, rdy && ms_allowin && mem);
         chk("fwd_dest", es_to_ds_dest, ins.inst_no_dest ? 5'd0 : ins.dest);
         chk("fwd_load", es_to_ds_load, ins.res_from_mem);
         chk("debug_pc", debug_es_pc, ins.pc);
         if (es_to_ms_valid) begin
            if (lat < 0) lat = c;
            chk("bus", es_to_ms_bus, exp_bus);
            chk("fwd_result", es_to_ds_result, exp_res);
            if (ms_allowin) begin
               res  = es_to_ms_bus[64:33];
               we   = data_sram_we;
               wd   = data_sram_wdata;
               done = 1'b1;
               if (mem) chk("sram_addr", data_sram_addr, exp_res);
               if (ins.mem_we) begin
                  chk("sram_we", data_sram_we, st[35:32]);
                  chk("sram_wdata", data_sram_wdata, st[31:0]);
               end else begin
                  chk("sram_we_nostore", data_sram_we, 4'd0);
               end
            end
            vcnt++;
         end
         @(posedge clk); #1;
         if (done) break;
      end
      chk("transferred", done, 1'b1);
      chk("latency", lat, exp_lat);
      ms_allowin = 1'b1;
      #2;
      chk("drained_valid", es_to_ms_valid, 1'b0);
      chk("drained_allowin", es_allowin, 1'b1);
      chk("drained_en", data_sram_en, 1'b0);
      @(posedge clk); #1;
   endtask

   int          lat;
   logic [31:0] res, wd;
   logic [3:0]  we;
   ds_to_es_t   ins;

   initial begin
      resetn         = 1'b0;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      #2;
      chk("rst_allowin", es_allowin, 1'b1);
      chk("rst_ms_valid", es_to_ms_valid, 1'b0);
      chk("rst_en", data_sram_en, 1'b0);
      chk("rst_we", data_sram_we, 4'd0);
      chk("rst_dest", es_to_ds_dest, 5'd0);
      chk("rst_load", es_to_ds_load, 1'b0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      issue(mk_alu(0, 32'd5, 32'd7), 0, lat, res, we, wd);
      chk("add_result", res, 32'd12);
      chk("add_latency", lat, 0);

      issue(mk_div(DIV_W, 32'hFFFFFFF9, 32'd2), 0, lat, res, we, wd);
      chk("divw_result", res, 32'hFFFFFFFD);
      chk("divw_latency", lat, 33);
      issue(mk_div(MOD_W, 32'hFFFFFFF9, 32'd2), 0, lat, res, we, wd);
      chk("modw_result", res, 32'hFFFFFFFF);
      issue(mk_div(DIV_WU, 32'd100, 32'd0), 0, lat, res, we, wd);
      chk("divwu_by0", res, 32'hFFFFFFFF);
      issue(mk_div(MOD_WU, 32'd100, 32'd0), 0, lat, res, we, wd);
      chk("modwu_by0", res, 32'd100);
      issue(mk_div(DIV_W, 32'h80000000, 32'hFFFFFFFF), 0, lat, res, we, wd);
      chk("divw_ovf", res, 32'h80000000);

      issue(mk_store(ST_B, 32'h1003, 32'h12345678), 0, lat, res, we, wd);
      chk("stb_we", we, 4'b1000);
      chk("stb_wdata", wd, 32'h78787878);
      issue(mk_store(ST_H, 32'h1001, 32'h12345678), 0, lat, res, we, wd);
      chk("sth_misaligned_we", we, 4'b0000);

      issue(mk_div(DIV_W, 32'hFFFFFFF9, 32'd2), 5, lat, res, we, wd);
      chk("div_stall_result", res, 32'hFFFFFFFD);
      issue(mk_store(ST_W, 32'h2000, 32'hCAFEF00D), 5, lat, res, we, wd);
      chk("stw_stall_we", we, 4'b1111);

      // Reset in the middle of a divide (BUSY, count 10).
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk_div(DIV_W, 32'hFFFFFFF9, 32'd2);
      @(posedge clk); #1;
      ds_to_es_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("mid_div_busy", es_to_ms_valid, 1'b0);
      chk("mid_div_allowin", es_allowin, 1'b0);
      resetn = 1'b0;
      #1;
      chk("midrst_allowin", es_allowin, 1'b1);
      chk("midrst_ms_valid", es_to_ms_valid, 1'b0);
      chk("midrst_load", es_to_ds_load, 1'b0);
      chk("midrst_dest", es_to_ds_dest, 5'd0);
      chk("midrst_en", data_sram_en, 1'b0);
      @(posedge clk); #1;
      resetn = 1'b1;
      issue(mk_div(DIV_WU, 32'd1000, 32'd7), 0, lat, res, we, wd);
      chk("postrst_div_result", res, 32'd142);
      chk("postrst_div_latency", lat, 33);

      for (int i = 0; i < 40; i++) begin
         int stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         case ($urandom_range(0, 3))
            0: ins = mk_alu(int'($urandom_range(0, 11)), pick_op(), pick_op());
            1: ins = mk_load($urandom);
            2: ins = mk_store(2'($urandom_range(0, 3)), $urandom, $urandom);
            default: ins = mk_div(2'($urandom_range(0, 3)), pick_op(), pick_op());
         endcase
         issue(ins, stall, lat, res, we, wd);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock) and resetn (in, 1); one clock; reset is asynchronous and active-low.
REQ-002 SHALL have ms_allowin (in, 1), es_allowin (out, 1): pipeline backpressure.
REQ-003 SHALL have ds_to_es_valid (in, 1) and ds_to_es_bus (in, `DS_TO_ES_BUS_WD`): decoded instruction.
REQ-004 SHALL have es_to_ms_valid (out, 1) and es_to_ms_bus (out, `ES_TO_MS_BUS_WD`=77): {res_from_mem, ld_type[2:0], gr_we, st_type[1:0], dest[4:0], alu_result[31:0], pc[31:0], inst_no_dest}, MSB first.
REQ-005 SHALL have es_to_ds_dest (out, 5), es_to_ds_result (out, 32), es_to_ds_load (out, 1): forwarding and load-use stall.
REQ-006 SHALL have data_sram_en (out, 1), data_sram_we (out, 4), data_sram_addr (out, 32), data_sram_wdata (out, 32).
REQ-007 SHALL have debug_es_pc (out, 32): current pc.

Function
REQ-010 es_valid SHALL load ds_to_es_valid when es_allowin; es_allowin = !es_valid | (es_ready_go & ms_allowin); es_to_ms_valid = es_valid & es_ready_go.
REQ-011 Input bus SHALL be registered only when ds_to_es_valid & es_allowin; otherwise held.
REQ-012 Non-divide result SHALL come from existing combinational alu (alu_op[11:0], src1, src2); es_ready_go = 1, residency 1 cycle.
REQ-013 Divide ops (div_op: 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu, gated by div_en) SHALL use FSM IDLE->BUSY->DONE: IDLE->BUSY on es_valid & div_en; BUSY exactly 32 cycles (5-bit counter 0..31); BUSY->DONE at count 31; DONE->IDLE when es_ready_go & ms_allowin.
REQ-014 es_ready_go SHALL be !div_en | (state==DONE); first asserted 33 cycles after instruction enters (34 cycles residency with ms_allowin=1).
REQ-015 Divide by zero: quotient 0xFFFFFFFF, remainder = dividend; no exception.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-017 Signed results: quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-018 DONE SHALL hold result while ms_allowin=0; no restart until DONE->IDLE.
REQ-019 data_sram_en SHALL be es_valid & es_ready_go & ms_allowin & (load|store): one request per memory instruction, none under stall.
REQ-020 data_sram_addr = alu_result; data_sram_we: st.w (00) 4'b1111; st.b (01) 1<<addr[1:0]; st.h (10) 4'b0011/4'b1100 for addr[1:0]=00/10; misaligned st.h/st.w and loads SHALL give 4'b0000.
REQ-021 data_sram_wdata SHALL replicate store byte x4 (st.b), halfword x2 (st.h), else rkd_value.
REQ-022 es_to_ds_dest = dest masked to 0 unless es_valid & !inst_no_dest; es_to_ds_load = es_valid & res_from_mem; es_to_ds_result = final result (meaningful only when es_ready_go).
REQ-023 Final result SHALL select divider output when div_en, else alu_result.

Reset
REQ-030 On resetn=0 (any cycle, incl. mid-divide): es_valid=0, FSM=IDLE, counter=0, data_sram_en=0, data_sram_we=0, es_to_ms_valid=0, es_to_ds_dest=0, es_to_ds_load=0; es_allowin=1.
REQ-031 Bus register need not reset; no output SHALL depend on it while es_valid=0.

Structure
REQ-040 Bus widths, div_op/st_type/ld_type encodings SHALL live in shared mycpu_head.v.
REQ-041 Divider SHALL be sub-module div_iter (radix-2 restoring, start/done handshake, sign fixup inside).

Verification
REQ-050 add.w 5+7, ms_allowin=1 -> es_to_ms_valid one cycle after entry, alu_result 12.
REQ-051 div.w 0xFFFFFFF9 / 2 -> ready_go at cycle 33, result 0xFFFFFFFD; mod.w same -> 0xFFFFFFFF.
REQ-052 div.wu 100/0 -> 0xFFFFFFFF; mod.wu 100/0 -> 100; div.w 0x80000000/-1 -> 0x80000000.
REQ-053 st.b data 0x12345678 addr 0x1003 -> we 4'b1000, wdata 0x78787878; st.h addr 0x1001 -> we 0.
REQ-054 div in DONE, ms_allowin low 5 cycles -> result held, single data_sram_en=0, one transfer when released.
REQ-055 resetn low at BUSY count 10 -> es_valid=0, FSM IDLE; following div completes in 34 cycles.
